// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared types and constants for the execute/writeback stage
package exec_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLL = 3'd5,
    OP_SRL = 3'd6,
    OP_MUL = 3'd7
  } exec_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } exec_state_t;

  // Only the low nibble of operand B is used as a shift amount
  localparam int SHAMT_W = 4;

endpackage

// File: rtl/mul_iter.sv
// rtl/mul_iter.sv - iterative shift-add multiplier, one partial product per clock
module mul_iter #(
  parameter int width = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic             done,
  output logic [width-1:0] product,
  output logic             ovf
);

  localparam int CNT_W = $clog2(width);

  logic               busy;
  logic [CNT_W-1:0]   cnt;
  logic [2*width-1:0] acc;
  logic [2*width-1:0] mcand;
  logic [2*width-1:0] acc_next;
  logic [width-1:0]   mplier;

  // The final iteration's partial product is folded in combinationally so the
  // full product is available on the same edge that the counter hits width-1.
  assign acc_next = mplier[0] ? (acc + mcand) : acc;
  assign done     = busy && (cnt == CNT_W'(width - 1));
  assign product  = acc_next[width-1:0];
  assign ovf      = |acc_next[2*width-1:width];

  // Operand latch on start, then one shift-add step per cycle until done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (abort) begin
      busy <= 1'b0;
      cnt  <= '0;
      acc  <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= {{width{1'b0}}, a};
      mplier <= b;
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= done ? '0 : cnt + 1'b1;
      busy   <= !done;
    end
  end

endmodule

// File: rtl/exec_wb.sv
// rtl/exec_wb.sv - execute/writeback stage: ALU, iterative MUL, flags, RF write port
module exec_wb
  import exec_pkg::*;
#(
  parameter int width = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [2:0]       op,
  input  logic [width-1:0] rs_val,
  input  logic [width-1:0] rt_val,
  input  logic [1:0]       rd_sel,
  input  logic             flush,
  output logic             write,
  output logic [1:0]       rd_addr,
  output logic [width-1:0] rd_in,
  output logic             zero_flag,
  output logic             carry_flag
);

  exec_state_t        state;
  exec_state_t        state_next;
  exec_op_t           op_e;
  logic               accept;
  logic               mul_start;
  logic               mul_abort;
  logic               mul_done;
  logic               mul_commit;
  logic [width-1:0]   mul_product;
  logic               mul_ovf;
  logic [1:0]         rd_lat;
  logic [width-1:0]   alu_res;
  logic               alu_carry;
  logic [SHAMT_W-1:0] shamt;

  assign op_e       = exec_op_t'(op);
  assign ready_out  = (state == IDLE);
  assign accept     = valid_in && ready_out;
  assign mul_start  = accept && (op_e == OP_MUL);
  assign mul_abort  = (state == MUL) && flush;
  assign mul_commit = (state == MUL) && !flush && mul_done;
  assign shamt      = rt_val[SHAMT_W-1:0];

  mul_iter #(.width(width)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .abort   (mul_abort),
    .a       (rs_val),
    .b       (rt_val),
    .done    (mul_done),
    .product (mul_product),
    .ovf     (mul_ovf)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state: flush beats a completing MUL so an aborted op never writes
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (mul_start) state_next = MUL;
      MUL:     if (flush || mul_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Single-cycle ALU; logic ops and shifts pass the current carry through
  always_comb begin
    alu_res   = '0;
    alu_carry = carry_flag;
    case (op_e)
      OP_ADD: {alu_carry, alu_res} = {1'b0, rs_val} + {1'b0, rt_val};
      OP_SUB: {alu_carry, alu_res} = {1'b0, rs_val} - {1'b0, rt_val};
      OP_AND: alu_res = rs_val & rt_val;
      OP_OR:  alu_res = rs_val | rt_val;
      OP_XOR: alu_res = rs_val ^ rt_val;
      OP_SLL: alu_res = (int'(shamt) >= width) ? '0 : (rs_val << shamt);
      OP_SRL: alu_res = (int'(shamt) >= width) ? '0 : (rs_val >> shamt);
      default: alu_res = '0;
    endcase
  end

  // Writeback registers: strobe for one cycle, results and flags held otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write      <= 1'b0;
      rd_addr    <= '0;
      rd_in      <= '0;
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
      rd_lat     <= '0;
    end else begin
      write <= 1'b0;
      if (mul_start) rd_lat <= rd_sel;
      if (accept && (op_e != OP_MUL)) begin
        write      <= 1'b1;
        rd_in      <= alu_res;
        rd_addr    <= rd_sel;
        zero_flag  <= (alu_res == '0);
        carry_flag <= alu_carry;
      end else if (mul_commit) begin
        write      <= 1'b1;
        rd_in      <= mul_product;
        rd_addr    <= rd_lat;
        zero_flag  <= (mul_product == '0);
        carry_flag <= mul_ovf;
      end
    end
  end

endmodule

// File: tb/tb_exec_wb.sv
// tb/tb_exec_wb.sv - self-checking bench for exec_wb against an arithmetic reference model
module tb_exec_wb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_in;
  logic       ready_out;
  logic [2:0] op;
  logic [8:0] rs_val;
  logic [8:0] rt_val;
  logic [1:0] rd_sel;
  logic       flush;
  logic       write;
  logic [1:0] rd_addr;
  logic [8:0] rd_in;
  logic       zero_flag;
  logic       carry_flag;

  int n_cmp = 0;
  int n_bad = 0;

  int m_rd = 0;
  int m_addr = 0;
  int m_zero = 0;
  int m_carry = 0;

  always #5 clk = ~clk;

  exec_wb #(.width(9)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .op         (op),
    .rs_val     (rs_val),
    .rt_val     (rt_val),
    .rd_sel     (rd_sel),
    .flush      (flush),
    .write      (write),
    .rd_addr    (rd_addr),
    .rd_in      (rd_in),
    .zero_flag  (zero_flag),
    .carry_flag (carry_flag)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input int o, input int a, input int b, input int s);
    int r;
    int c;
    c = m_carry;
    case (o)
      0: begin r = a + b; c = (r > 511); end
      1: begin r = a - b; c = (a < b); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = ((b % 16) >= 9) ? 0 : (a << (b % 16));
      6: r = a >> (b % 16);
      default: begin r = a * b; c = (r > 511); end
    endcase
    r = r & 511;
    m_rd = r;
    m_addr = s;
    m_zero = (r == 0);
    m_carry = c;
  endtask

  task automatic check_held(input string tag);
    chk({tag, " rd_in"}, rd_in, m_rd);
    chk({tag, " rd_addr"}, rd_addr, m_addr);
    chk({tag, " zero"}, zero_flag, m_zero);
    chk({tag, " carry"}, carry_flag, m_carry);
  endtask

  task automatic check_write(input string tag);
    chk({tag, " write"}, write, 1);
    check_held(tag);
  endtask

  task automatic drive(input int o, input int a, input int b, input int s);
    valid_in = 1'b1;
    op = 3'(o);
    rs_val = 9'(a);
    rt_val = 9'(b);
    rd_sel = 2'(s);
  endtask

  // Issue one op from a negedge; MUL timing is checked cycle by cycle. With
  // hold_add, an ADD (ha+hb -> hs) is held valid throughout the MUL busy window.
  task automatic do_op(input string tag, input int o, input int a, input int b, input int s,
                       input bit hold_add, input int ha, input int hb, input int hs);
    int w;
    w = 0;
    while (!ready_out && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (w >= 20) chk({tag, " ready_wait"}, ready_out, 1);
    drive(o, a, b, s);
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    if (o != 7) begin
      model(o, a, b, s);
      check_write(tag);
    end else begin
      for (int n = 1; n <= 9; n++) begin
        if (n == 1 && hold_add) drive(0, ha, hb, hs);
        chk({tag, " busy write"}, write, 0);
        chk({tag, " busy ready"}, ready_out, 0);
        @(negedge clk);
      end
      model(o, a, b, s);
      check_write(tag);
      chk({tag, " ready back"}, ready_out, 1);
      if (hold_add) begin
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        model(0, ha, hb, hs);
        check_write({tag, " held add"});
      end
    end
  endtask

  // MUL interrupted at busy cycle 4 by reset or flush; must never write
  task automatic abort_mul(input string tag, input int a, input int b, input int s, input bit use_reset);
    drive(7, a, b, s);
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      chk({tag, " pre write"}, write, 0);
      @(negedge clk);
    end
    if (use_reset) begin
      rst_n = 1'b0;
      #1;
      m_rd = 0; m_addr = 0; m_zero = 0; m_carry = 0;
      chk({tag, " in-reset write"}, write, 0);
      check_held({tag, " in-reset"});
      @(negedge clk);
      rst_n = 1'b1;
    end else begin
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
    end
    @(negedge clk);
    chk({tag, " ready"}, ready_out, 1);
    for (int n = 0; n < 12; n++) begin
      chk({tag, " no write"}, write, 0);
      @(negedge clk);
    end
    check_held({tag, " after"});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int o, a, b, s;
    rst_n = 1'b0;
    valid_in = 1'b0;
    op = '0;
    rs_val = '0;
    rt_val = '0;
    rd_sel = '0;
    flush = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset write", write, 0);
    check_held("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset ready", ready_out, 1);
    chk("post-reset write", write, 0);

    do_op("add", 0, 'h1F0, 'h020, 2, 0, 0, 0, 0);
    chk("add value", rd_in, 'h010);

    drive(1, 5, 7, 1);
    @(posedge clk);
    @(negedge clk);
    model(1, 5, 7, 1);
    drive(2, 'h0F0, 'h00F, 3);
    check_write("sub b2b");
    chk("sub value", rd_in, 'h1FE);
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    model(2, 'h0F0, 'h00F, 3);
    check_write("and b2b");
    chk("and zero", zero_flag, 1);
    @(negedge clk);
    chk("idle write", write, 0);

    do_op("mul 23x22", 7, 23, 22, 1, 0, 0, 0, 0);
    chk("mul 23x22 value", rd_in, 'h1FA);
    do_op("mul 30x20", 7, 30, 20, 0, 0, 0, 0, 0);
    chk("mul 30x20 value", rd_in, 'h058);
    do_op("sll 10", 5, 'h001, 10, 2, 0, 0, 0, 0);
    do_op("srl 8", 6, 'h100, 8, 3, 0, 0, 0, 0);
    chk("srl carry kept", carry_flag, 1);

    do_op("mul hold", 7, 17, 19, 2, 1, 'h1FF, 'h001, 1);

    flush = 1'b1;
    do_op("flush idle add", 0, 3, 4, 1, 0, 0, 0, 0);
    flush = 1'b0;

    abort_mul("flush mul", 25, 25, 3, 0);
    abort_mul("reset mul", 25, 25, 3, 1);

    for (int i = 0; i < 40; i++) begin
      o = $urandom_range(0, 7);
      a = $urandom_range(0, 511);
      b = (o == 5 || o == 6) ? $urandom_range(0, 15) : $urandom_range(0, 511);
      s = $urandom_range(0, 3);
      do_op("rand", o, a, b, s, 1'($urandom_range(0, 1)),
            $urandom_range(0, 511), $urandom_range(0, 511), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/exec_wb.md
# exec_wb

Execute/writeback stage for the 9-bit emulator datapath. Consumes the two register-file read values (`rs_out`, `rt_out`) plus a decoded opcode, computes an ALU or iterative-multiply result, and drives the register-file write port (`write`, `rd_addr`, `rd_in`) one pulse per accepted operation. Sits directly between register-file read and register-file write. Maintains the zero/carry flags consumed by branch decode.

## Interface
- `width`, 9: datapath width in bits
- `clk`  input  1  rising-edge clock
- `rst_n`  input  1  asynchronous active-low reset
- `valid_in`  input  1  operation presented this cycle
- `ready_out`  output  1  stage can accept; high iff state IDLE
- `op`  input  3  opcode (exec_op_t)
- `rs_val`  input  width  operand A (from `rs_out`)
- `rt_val`  input  width  operand B (from `rt_out`)
- `rd_sel`  input  2  destination index (register file adds 8)
- `flush`  input  1  synchronous abort of in-flight MUL
- `write`  output  1  one-cycle write strobe to register file
- `rd_addr`  output  2  registered destination index
- `rd_in`  output  width  registered result
- `zero_flag`  output  1  result of last written op == 0
- `carry_flag`  output  1  carry/borrow/overflow of last arithmetic op

## Operation
- Accept on rising edge where `valid_in && ready_out`; `valid_in` while not ready is ignored (no queueing).
- Ops: ADD=0 (A+B), SUB=1 (A−B), AND=2, OR=3, XOR=4, SLL=5 (A<<B[3:0]), SRL=6 (A>>B[3:0], logical), MUL=7.
- All results truncated to `width` bits. Shift amount ≥ `width` yields 0.
- Carry: ADD = carry out of bit width−1. SUB = borrow (A<B unsigned). MUL = any product bit ≥ width set. AND/OR/XOR/SLL/SRL leave carry unchanged.
- Zero flag updated on every write from the written `rd_in`.
- FSM: IDLE, MUL.
  - IDLE + accept of non-MUL: result, `rd_sel`, flags registered same edge; `write`=1 next cycle; stay IDLE.
  - IDLE + accept of MUL: latch A, B, `rd_sel`; clear accumulator and counter; go MUL; `write`=0.
  - MUL: one shift-add iteration per edge, counter 0..width−1; on edge with counter==width−1, register product/flags, `write`=1, go IDLE.
  - MUL + `flush`: go IDLE next edge; no write; flags unchanged.
  - `flush` in IDLE: no effect; an accept in the same cycle is still taken.
- `write` low in every cycle not immediately following a completion edge.
- `rd_in`/`rd_addr` hold their last value between writes.

## Timing
- Reset (async, any state): state IDLE, `write`=0, `rd_in`=0, `rd_addr`=0, `zero_flag`=0, `carry_flag`=0, MUL counter/accumulator 0; `ready_out`=1 once reset released. Reset mid-MUL discards the op with no write.
- Non-MUL latency: `write` high in the cycle after acceptance edge; throughput 1 op/cycle.
- MUL latency: `write` high in the cycle after edge width following acceptance (width+1 cycles); `ready_out` low for exactly width cycles; new op accepted on the same edge that completes the MUL is not possible (ready low), accepted on the next.
- Flags change only on the edge that asserts `write`.

## Structure
- `exec_pkg`: `exec_op_t` enum (3 bits, values above), `exec_state_t` enum {IDLE, MUL}, `SHAMT_W`=4 constant.
- Sub-module `mul_iter`: shift-add multiplier (start, operands, counter, accumulator, done pulse, 2·width internal product for overflow detect); `exec_wb` holds FSM, ALU, flags, output registers.

## Test plan
- ADD 9'h1F0 + 9'h020, rd_sel=2 -> next cycle write=1, rd_in=9'h010, rd_addr=2, carry=1, zero=0.
- SUB 9'd5 − 9'd7 then AND 9'h0F0 & 9'h00F back-to-back -> writes on consecutive cycles: 9'h1FE carry=1, then 9'h000 zero=1 carry still 1.
- MUL 23×22 -> ready low 9 cycles, single write 10 cycles after accept, rd_in=9'h1FA carry=0; MUL 30×20 -> rd_in=9'h058 carry=1.
- SLL 9'h001 by rt_val=10; SRL 9'h100 by 8 -> rd_in=0 zero=1; rd_in=9'h001 zero=0; carry unchanged.
- valid_in held high with ADD during MUL busy -> ignored; only MUL write occurs, ADD accepted only once ready returns.
- rst_n low at MUL cycle 4 (and separately flush at cycle 4) -> no write ever for that op, outputs/flags at reset values (flush: previous values), ready_out=1 next cycle.
